// File: rtl/dsc_pkg.sv
// rtl/dsc_pkg.sv - shared types, defaults and helpers for the dsc_mul sequencer
//
// Holds the controller state encoding, the default operand geometry and the
// helper that derives the default RUN-cycle budget from the product width.
package dsc_pkg;

  localparam int NUM_INPUTS_DEF = 4;
  localparam int NUM_BITS_DEF   = 4;
  localparam int PROD_W         = NUM_INPUTS_DEF * NUM_BITS_DEF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    RUN       = 3'd2,
    SETTLE_ST = 3'd3,
    RESP      = 3'd4
  } ctrl_state_t;

  // A deterministic stochastic multiply of prod_w bits takes 2^prod_w
  // cycles; a few extra cycles of slack keep a healthy multiplier clear of
  // the timeout.
  function automatic int default_max_cyc(input int prod_w);
    return (1 << prod_w) + 4;
  endfunction

endpackage

// File: rtl/dsc_stat_acc.sv
// rtl/dsc_stat_acc.sv - saturating statistics accumulator
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset (clears acc)
//   add_en, add_val  add add_val to acc on this edge
//   acc              running sum, sticks at all-ones instead of wrapping
module dsc_stat_acc
  import dsc_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             add_en,
  input  logic [ACC_W-1:0] add_val,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W:0] sum;

  // One extra bit catches the carry that signals saturation.
  assign sum = {1'b0, acc} + {1'b0, add_val};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/dsc_mul_ctrl.sv
// rtl/dsc_mul_ctrl.sv - request/response sequencer around one dsc_mul
//
// Accepts one operand set at a time, clears and enables the multiplier,
// waits for its done flag (or a cycle budget), captures the product and the
// run length, returns them over a valid/ready pair and keeps statistics.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   in_valid/in_ready/in_ops      operand set request, operand 0 in the LSBs
//   out_valid/out_ready           result handshake
//   out_z/out_cycles/out_timeout  captured product, RUN cycles, forced flag
//   mul_rst/mul_en                active-high clear and enable to dsc_mul
//   mul_a..mul_d                  registered operands to dsc_mul
//   mul_z/mul_ov                  dsc_mul product and done flag
//   busy                          controller is not idle
//   stat_ops/stat_cyc_acc         saturating completion count and cycle sum
module dsc_mul_ctrl
  import dsc_pkg::*;
#(
  parameter int NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int NUM_BITS   = NUM_BITS_DEF,
  parameter int CYC_W      = 20,
  parameter int MAX_CYC    = default_max_cyc(NUM_INPUTS * NUM_BITS),
  parameter int SETTLE     = 1,
  parameter int ACC_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_INPUTS*NUM_BITS-1:0] in_ops,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_INPUTS*NUM_BITS-1:0] out_z,
  output logic [CYC_W-1:0]               out_cycles,
  output logic                           out_timeout,
  output logic                           mul_rst,
  output logic                           mul_en,
  output logic [NUM_BITS-1:0]            mul_a,
  output logic [NUM_BITS-1:0]            mul_b,
  output logic [NUM_BITS-1:0]            mul_c,
  output logic [NUM_BITS-1:0]            mul_d,
  input  logic [NUM_INPUTS*NUM_BITS-1:0] mul_z,
  input  logic                           mul_ov,
  output logic                           busy,
  output logic [ACC_W-1:0]               stat_ops,
  output logic [ACC_W-1:0]               stat_cyc_acc
);

  localparam logic [CYC_W-1:0] MAX_CYC_C   = CYC_W'(MAX_CYC);
  localparam logic [1:0]       SETTLE_INIT = 2'(SETTLE - 1);
  localparam longint           CYC_LIMIT   = longint'(1) << CYC_W;
  localparam bit               CFG_OK      = (longint'(MAX_CYC) < CYC_LIMIT) &&
                                             (MAX_CYC >= 1) &&
                                             (SETTLE >= 1) && (SETTLE <= 3) &&
                                             (NUM_INPUTS >= 4) &&
                                             (ACC_W >= CYC_W);

  ctrl_state_t      state, state_d;
  logic [CYC_W-1:0] cnt, cnt_d, cnt_inc;
  logic             to_flag, to_flag_d;
  logic [1:0]       settle_cnt, settle_cnt_d;
  logic             accept;
  logic             capture;

  // The run counter sticks at all-ones so a runaway can never alias to a
  // small cycle count.
  assign cnt_inc = (&cnt) ? cnt : cnt + CYC_W'(1);

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    to_flag_d    = to_flag;
    settle_cnt_d = settle_cnt;
    accept       = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // The cycle that sees mul_ov still counts as a RUN cycle, and a done
        // flag arriving on the budget's last cycle is a real completion.
        cnt_d = cnt_inc;
        if (mul_ov) begin
          to_flag_d    = 1'b0;
          settle_cnt_d = SETTLE_INIT;
          state_d      = SETTLE_ST;
        end else if (cnt_inc == MAX_CYC_C) begin
          to_flag_d    = 1'b1;
          settle_cnt_d = SETTLE_INIT;
          state_d      = SETTLE_ST;
        end
      end
      SETTLE_ST: begin
        // Gives the multiplier's z output time to settle after its enable
        // drops before the product is sampled.
        if (settle_cnt == 2'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          settle_cnt_d = settle_cnt - 2'd1;
        end
      end
      RESP: begin
        if (out_valid && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every handshake and multiplier control output is a register decoded from
  // the next state, so it lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      to_flag     <= 1'b0;
      settle_cnt  <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      mul_rst     <= 1'b1;
      mul_en      <= 1'b0;
      out_z       <= '0;
      out_cycles  <= '0;
      out_timeout <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_c       <= '0;
      mul_d       <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      to_flag    <= to_flag_d;
      settle_cnt <= settle_cnt_d;
      in_ready   <= (state_d == IDLE);
      out_valid  <= (state_d == RESP);
      busy       <= (state_d != IDLE);
      mul_en     <= (state_d == RUN);
      mul_rst    <= !((state_d == RUN) || (state_d == SETTLE_ST));
      if (accept) begin
        mul_a <= in_ops[0*NUM_BITS +: NUM_BITS];
        mul_b <= in_ops[1*NUM_BITS +: NUM_BITS];
        mul_c <= in_ops[2*NUM_BITS +: NUM_BITS];
        mul_d <= in_ops[3*NUM_BITS +: NUM_BITS];
      end
      if (capture) begin
        out_z       <= mul_z;
        out_cycles  <= cnt;
        out_timeout <= to_flag;
      end
    end
  end

  dsc_stat_acc #(.ACC_W(ACC_W)) u_stat_ops (
    .clk     (clk),
    .resetn  (rst),
    .add_en  (capture),
    .add_val (ACC_W'(1)),
    .acc     (stat_ops)
  );

  dsc_stat_acc #(.ACC_W(ACC_W)) u_stat_cyc (
    .clk     (clk),
    .resetn  (rst),
    .add_en  (capture),
    .add_val (ACC_W'(cnt)),
    .acc     (stat_cyc_acc)
  );

  always_ff @(posedge clk) begin
    assert (CFG_OK) else $error("dsc_mul_ctrl: illegal parameter combination");
  end

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// tb/tb_dsc_mul_ctrl.sv - self-checking bench for dsc_mul_ctrl
module tb_dsc_mul_ctrl;
  import dsc_pkg::*;

  localparam int NB   = NUM_BITS_DEF;
  localparam int PW   = PROD_W;
  localparam int SET  = 1;
  localparam int MAXB = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, out_ready, in_valid_a, in_valid_b;
  logic [PW-1:0] in_ops;

  logic          in_ready_a, out_valid_a, out_timeout_a, mul_rst_a, mul_en_a, busy_a, mul_ov_a;
  logic [PW-1:0] out_z_a, mul_z_a;
  logic [19:0]   out_cycles_a;
  logic [NB-1:0] ma_a, mb_a, mc_a, md_a;
  logic [31:0]   stat_ops_a, stat_cyc_a;

  logic          in_ready_b, out_valid_b, out_timeout_b, mul_rst_b, mul_en_b, busy_b, mul_ov_b;
  logic [PW-1:0] out_z_b, mul_z_b;
  logic [19:0]   out_cycles_b;
  logic [NB-1:0] ma_b, mb_b, mc_b, md_b;
  logic [31:0]   stat_ops_b, stat_cyc_b;

  dsc_mul_ctrl dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_ops(in_ops),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_z(out_z_a), .out_cycles(out_cycles_a),
    .out_timeout(out_timeout_a), .mul_rst(mul_rst_a), .mul_en(mul_en_a),
    .mul_a(ma_a), .mul_b(mb_a), .mul_c(mc_a), .mul_d(md_a), .mul_z(mul_z_a), .mul_ov(mul_ov_a),
    .busy(busy_a), .stat_ops(stat_ops_a), .stat_cyc_acc(stat_cyc_a)
  );

  dsc_mul_ctrl #(.MAX_CYC(MAXB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_ops(in_ops),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_z(out_z_b), .out_cycles(out_cycles_b),
    .out_timeout(out_timeout_b), .mul_rst(mul_rst_b), .mul_en(mul_en_b),
    .mul_a(ma_b), .mul_b(mb_b), .mul_c(mc_b), .mul_d(md_b), .mul_z(mul_z_b), .mul_ov(mul_ov_b),
    .busy(busy_b), .stat_ops(stat_ops_b), .stat_cyc_acc(stat_cyc_b)
  );

  // Multiplier A: either a true deterministic stochastic multiplier (each
  // operand j is a unary stream "digit j of the run index < op_j", the
  // product is the count of cycles where all streams are 1 over 2^16
  // cycles), or a stub that raises ov on RUN cycle k_a (k_a==0: never).
  logic        stream_a, ov_force_a;
  int          k_a, run_a;
  logic [15:0] idx_a, zacc_a;
  logic        and_a;
  always_comb and_a = (idx_a[3:0] < ma_a) && (idx_a[7:4] < mb_a) &&
                      (idx_a[11:8] < mc_a) && (idx_a[15:12] < md_a);
  always @(posedge clk) begin
    if (mul_rst_a) begin
      idx_a <= '0; zacc_a <= '0; run_a <= 0;
    end else if (mul_en_a) begin
      idx_a <= idx_a + 16'd1; run_a <= run_a + 1;
      if (and_a) zacc_a <= zacc_a + 16'd1;
    end
  end
  assign mul_z_a  = stream_a ? zacc_a : PW'(PW'(ma_a) * PW'(mb_a) * PW'(mc_a) * PW'(md_a));
  assign mul_ov_a = ov_force_a || (mul_en_a && (stream_a ? (idx_a == 16'hFFFF)
                                                         : (k_a != 0 && run_a == k_a - 1)));

  int k_b, run_b;
  always @(posedge clk) begin
    if (mul_rst_b) run_b <= 0;
    else if (mul_en_b) run_b <= run_b + 1;
  end
  assign mul_z_b  = PW'(PW'(ma_b) * PW'(mb_b) * PW'(mc_b) * PW'(md_b));
  assign mul_ov_b = mul_en_b && (k_b != 0 && run_b == k_b - 1);

  int checks = 0;
  int errors = 0;
  int exp_ops_a = 0;
  int exp_cyc_a = 0;

  function automatic int prod_of(input logic [PW-1:0] ops);
    return int'(ops[3:0]) * int'(ops[7:4]) * int'(ops[11:8]) * int'(ops[15:12]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    in_valid_a = 0; in_valid_b = 0; out_ready = 0; rst = 0;
    @(negedge clk);
    rst = 1; exp_ops_a = 0; exp_cyc_a = 0;
  endtask

  // Presents one operand set and waits (bounded) for out_valid; leaves the
  // DUT in RESP. Latency counts edges from the acceptance edge.
  task automatic run_op(input bit use_b, input logic [PW-1:0] ops, input bit stream, input int k,
                        input int bound, output logic [PW-1:0] z, output int cyc, output bit to,
                        output int lat, output int en_cnt, output bit rst_clear, output bit rst_run,
                        output bit hung);
    int w;
    lat = 0; en_cnt = 0; w = 0; rst_run = 1'b1;
    @(negedge clk);
    if (use_b) k_b = k; else begin k_a = k; stream_a = stream; end
    in_ops = ops;
    if (use_b) in_valid_b = 1; else in_valid_a = 1;
    while (!(use_b ? in_ready_b : in_ready_a) && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    in_valid_a = 0; in_valid_b = 0;
    rst_clear = use_b ? mul_rst_b : mul_rst_a;
    while (!(use_b ? out_valid_b : out_valid_a) && lat < bound) begin
      @(posedge clk); #1; lat++;
      if (lat == 1) rst_run = use_b ? mul_rst_b : mul_rst_a;
      if (use_b ? mul_en_b : mul_en_a) en_cnt++;
    end
    hung = !(use_b ? out_valid_b : out_valid_a);
    z   = use_b ? out_z_b : out_z_a;
    cyc = int'(use_b ? out_cycles_b : out_cycles_a);
    to  = use_b ? out_timeout_b : out_timeout_a;
  endtask

  task automatic ack();
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b%b exp 11", in_ready_a, in_ready_b); end
    checks++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_valid_busy got %b%b%b exp 000", out_valid_a, busy_a, busy_b); end
    checks++; if (mul_rst_a !== 1'b1 || mul_en_a !== 1'b0) begin errors++; $display("FAIL reset_mul_ctl got rst=%b en=%b exp 1/0", mul_rst_a, mul_en_a); end
    checks++; if (out_z_a !== '0 || out_cycles_a !== '0 || out_timeout_a !== 1'b0) begin errors++; $display("FAIL reset_result got z=%0d c=%0d t=%b exp 0", out_z_a, out_cycles_a, out_timeout_a); end
    checks++; if ({ma_a, mb_a, mc_a, md_a} !== '0) begin errors++; $display("FAIL reset_operands got %h exp 0", {ma_a, mb_a, mc_a, md_a}); end
    checks++; if (stat_ops_a !== 32'd0 || stat_cyc_a !== 32'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_ops_a, stat_cyc_a); end
  endtask

  task automatic test_full_scale();
    logic [PW-1:0] z; int cyc, lat, en; bit to, rc, rr, hung;
    run_op(0, 16'hFFFF, 1, 0, 70000, z, cyc, to, lat, en, rc, rr, hung);
    checks++; if (hung) begin errors++; $display("FAIL full_hang got no out_valid exp out_valid"); end
    checks++; if (z !== 16'd50625) begin errors++; $display("FAIL full_z got %0d exp 50625", z); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL full_timeout got %b exp 0", to); end
    checks++; if (cyc != 65536 || cyc > 65536) begin errors++; $display("FAIL full_cycles got %0d exp 65536", cyc); end
    checks++; if (lat != 65536 + 1 + SET) begin errors++; $display("FAIL full_latency got %0d exp %0d", lat, 65536 + 1 + SET); end
    checks++; if (stat_ops_a !== 32'd1 || stat_cyc_a !== 32'd65536) begin errors++; $display("FAIL full_stats got %0d/%0d exp 1/65536", stat_ops_a, stat_cyc_a); end
    ack();
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] z; int cyc, lat, en, k1, k2; bit to, rc, rr, hung;
    do_reset();
    k1 = $urandom_range(1, 30); k2 = $urandom_range(1, 30);
    run_op(0, {4'd9, 4'd7, 4'd0, 4'd3}, 0, k1, 200, z, cyc, to, lat, en, rc, rr, hung);
    checks++; if (hung || z !== 16'd0 || cyc != k1) begin errors++; $display("FAIL b2b_first got z=%0d c=%0d hung=%b exp z=0 c=%0d", z, cyc, hung, k1); end
    ack();
    run_op(0, {4'd1, 4'd1, 4'd1, 4'd1}, 0, k2, 200, z, cyc, to, lat, en, rc, rr, hung);
    checks++; if (hung || z !== 16'd1 || cyc != k2 || to !== 1'b0) begin errors++; $display("FAIL b2b_second got z=%0d c=%0d t=%b exp z=1 c=%0d t=0", z, cyc, to, k2); end
    checks++; if (stat_ops_a !== 32'd2 || stat_cyc_a !== 32'(k1 + k2)) begin errors++; $display("FAIL b2b_stats got %0d/%0d exp 2/%0d", stat_ops_a, stat_cyc_a, k1 + k2); end
    ack();
    exp_ops_a = 2; exp_cyc_a = k1 + k2;
  endtask

  task automatic test_stub5();
    logic [PW-1:0] z, ops; int cyc, lat, en; bit to, rc, rr, hung;
    ops = PW'($urandom);
    run_op(0, ops, 0, 5, 200, z, cyc, to, lat, en, rc, rr, hung);
    checks++; if (hung || cyc != 5 || to !== 1'b0) begin errors++; $display("FAIL stub5_cycles got %0d t=%b exp 5 t=0", cyc, to); end
    checks++; if (lat != 1 + 5 + SET) begin errors++; $display("FAIL stub5_latency got %0d exp %0d", lat, 1 + 5 + SET); end
    checks++; if (en != 5) begin errors++; $display("FAIL stub5_en_cycles got %0d exp 5", en); end
    checks++; if (rc !== 1'b1 || rr !== 1'b0) begin errors++; $display("FAIL stub5_mul_rst got clear=%b run=%b exp 1/0", rc, rr); end
    checks++; if (z !== 16'(prod_of(ops))) begin errors++; $display("FAIL stub5_z got %0d exp %0d", z, prod_of(ops)); end
    ack();
    exp_ops_a++; exp_cyc_a += 5;
  endtask

  task automatic test_resp_stall();
    logic [PW-1:0] z, ops, ops2; int cyc, lat, en, bad; bit to, rc, rr, hung;
    ops = PW'($urandom);
    ops2 = PW'($urandom); ops2[3:0] = ops[3:0] ^ 4'hA;
    run_op(0, ops, 0, 3, 200, z, cyc, to, lat, en, rc, rr, hung);
    @(negedge clk); in_ops = ops2; in_valid_a = 1; k_a = 4;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid_a !== 1'b1 || out_z_a !== 16'(prod_of(ops)) || out_cycles_a !== 20'd3 ||
          in_ready_a !== 1'b0 || ma_a !== ops[3:0]) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles exp 0", bad); end
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || ma_a !== ops[3:0]) begin errors++; $display("FAIL stall_release got v=%b r=%b a=%h exp 0/1/%h", out_valid_a, in_ready_a, ma_a, ops[3:0]); end
    @(posedge clk); #1; in_valid_a = 0;
    checks++; if (ma_a !== ops2[3:0] || busy_a !== 1'b1) begin errors++; $display("FAIL stall_second_accept got a=%h busy=%b exp %h/1", ma_a, busy_a, ops2[3:0]); end
    lat = 0;
    while (!out_valid_a && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (out_valid_a !== 1'b1 || out_z_a !== 16'(prod_of(ops2)) || out_cycles_a !== 20'd4) begin errors++; $display("FAIL stall_second_result got z=%0d c=%0d exp %0d/4", out_z_a, out_cycles_a, prod_of(ops2)); end
    ack();
    exp_ops_a += 2; exp_cyc_a += 7;
  endtask

  task automatic test_spurious_ov();
    int bad;
    @(negedge clk); ov_force_a = 1; bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy_a !== 1'b0 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1) bad++;
    end
    ov_force_a = 0;
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_ov got %0d bad cycles exp 0", bad); end
    checks++; if (stat_ops_a !== 32'(exp_ops_a) || stat_cyc_a !== 32'(exp_cyc_a)) begin errors++; $display("FAIL idle_ov_stats got %0d/%0d exp %0d/%0d", stat_ops_a, stat_cyc_a, exp_ops_a, exp_cyc_a); end
  endtask

  task automatic test_reset_mid_run();
    logic [PW-1:0] z; int cyc, lat, en, seen; bit to, rc, rr, hung;
    @(negedge clk); k_a = 10; stream_a = 0; in_ops = PW'($urandom) | 16'h0001; in_valid_a = 1;
    @(posedge clk); #1; in_valid_a = 0;
    repeat (3) @(posedge clk);
    #1; rst = 0;
    @(posedge clk); #1; rst = 1;
    checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || busy_a !== 1'b0 || mul_en_a !== 1'b0 || mul_rst_a !== 1'b1) begin errors++; $display("FAIL midrst_ctl got r=%b v=%b b=%b en=%b rst=%b exp 1/0/0/0/1", in_ready_a, out_valid_a, busy_a, mul_en_a, mul_rst_a); end
    checks++; if (stat_ops_a !== 32'd0 || stat_cyc_a !== 32'd0 || ma_a !== 4'd0 || out_cycles_a !== 20'd0) begin errors++; $display("FAIL midrst_clear got %0d/%0d a=%h c=%0d exp 0", stat_ops_a, stat_cyc_a, ma_a, out_cycles_a); end
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid_a) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_result got %0d valid cycles exp 0", seen); end
    run_op(0, 16'h2345, 0, 4, 200, z, cyc, to, lat, en, rc, rr, hung);
    checks++; if (hung || cyc != 4 || z !== 16'd120 || stat_ops_a !== 32'd1 || stat_cyc_a !== 32'd4) begin errors++; $display("FAIL midrst_fresh got c=%0d z=%0d s=%0d/%0d exp 4/120/1/4", cyc, z, stat_ops_a, stat_cyc_a); end
    ack();
  endtask

  task automatic test_timeout();
    logic [PW-1:0] z; int cyc, lat, en; bit to, rc, rr, hung;
    int ks[3] = '{0, 20, 21};
    bit tos[3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_op(1, 16'h1234, 0, ks[i], 200, z, cyc, to, lat, en, rc, rr, hung);
      checks++; if (hung || to !== tos[i] || cyc != MAXB || lat != MAXB + 1 + SET) begin errors++; $display("FAIL timeout_k%0d got t=%b c=%0d lat=%0d exp t=%b c=%0d lat=%0d", ks[i], to, cyc, lat, tos[i], MAXB, MAXB + 1 + SET); end
      ack();
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] z, ops; int cyc, lat, en, k, ec, n_ops, sum_cyc; bit to, et, rc, rr, hung;
    do_reset();
    n_ops = 0; sum_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      ops = PW'($urandom);
      k = $urandom_range(0, 25);
      et = !(k != 0 && k <= MAXB);
      ec = et ? MAXB : k;
      run_op(1, ops, 0, k, 200, z, cyc, to, lat, en, rc, rr, hung);
      checks++; if (hung || z !== 16'(prod_of(ops)) || cyc != ec || to !== et || lat != ec + 1 + SET) begin errors++; $display("FAIL rand_%0d got z=%0d c=%0d t=%b lat=%0d exp z=%0d c=%0d t=%b lat=%0d", i, z, cyc, to, lat, prod_of(ops), ec, et, ec + 1 + SET); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack();
      n_ops++; sum_cyc += ec;
    end
    checks++; if (stat_ops_b !== 32'(n_ops) || stat_cyc_b !== 32'(sum_cyc)) begin errors++; $display("FAIL rand_stats got %0d/%0d exp %0d/%0d", stat_ops_b, stat_cyc_b, n_ops, sum_cyc); end
  endtask

  initial begin
    rst = 0; in_valid_a = 0; in_valid_b = 0; out_ready = 0; in_ops = '0;
    stream_a = 0; ov_force_a = 0; k_a = 0; k_b = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    test_reset();
    test_full_scale();
    test_back_to_back();
    test_stub5();
    test_resp_stall();
    test_spurious_ov();
    test_reset_mid_run();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsc_mul_ctrl.md
Name: dsc_mul_ctrl

Overview:
- Sequencer wrapping one dsc_mul (deterministic stochastic-computing multiplier: NUM_INPUTS operands of NUM_BITS each, z output, ov done flag).
- Accepts operand sets over valid/ready, clears and enables the multiplier, waits for ov, then captures z and the run length.
- Returns result, cycle count and timeout flag over valid/ready, and keeps running statistics.
- Sits between the system-side request source and the dsc_mul instance; replaces bench-driven rst/en sequencing.

Parameters:
- NUM_INPUTS, 4, operand count.
- NUM_BITS, 4, bits per operand.
- CYC_W, 20, width of the per-operation cycle counter.
- MAX_CYC, 65540, RUN cycles allowed before timeout; default is 2^(NUM_INPUTS*NUM_BITS)+4.
- SETTLE, 1, cycles between ov being sampled and z being captured (1..3).
- ACC_W, 32, width of the statistics accumulators.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-low reset: state is cleared on a rising clk edge where rst==0.
- in_valid, in, 1, operand set valid.
- in_ready, out, 1, controller can accept an operand set.
- in_ops, in, NUM_INPUTS*NUM_BITS, packed operands; operand 0 is in the LSBs.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts the result.
- out_z, out, NUM_INPUTS*NUM_BITS, captured product.
- out_cycles, out, CYC_W, number of RUN cycles used.
- out_timeout, out, 1, result was forced by timeout.
- mul_rst, out, 1, active-high reset to dsc_mul.
- mul_en, out, 1, enable to dsc_mul.
- mul_a, mul_b, mul_c, mul_d, out, NUM_BITS each, registered operands.
- mul_z, in, NUM_INPUTS*NUM_BITS, dsc_mul product.
- mul_ov, in, 1, dsc_mul done.
- busy, out, 1, state is not IDLE.
- stat_ops, out, ACC_W, completed operations, saturating.
- stat_cyc_acc, out, ACC_W, sum of out_cycles over all completions, saturating.

Behaviour:
- Reset values (rst==0 at an edge):
  - state=IDLE, in_ready=1, out_valid=0, mul_en=0, mul_rst=1.
  - out_z, out_cycles, out_timeout, operand registers, stat_ops, stat_cyc_acc all 0. busy=0.
- All outputs are registered. The state machine has five states:
  - IDLE: in_ready=1, mul_rst=1, mul_en=0. On in_valid&&in_ready, latch in_ops into mul_a..mul_d and go to CLEAR.
  - CLEAR (1 cycle): mul_rst=1, mul_en=0, cycle counter cleared to 0. Then go to RUN.
  - RUN: mul_rst=0, mul_en=1. The counter increments on every RUN cycle, including the cycle in which mul_ov is sampled high.
    - If mul_ov==1: go to SETTLE_ST with timeout flag 0.
    - Else, if the counter equals MAX_CYC: go to SETTLE_ST with timeout flag 1.
    - If both conditions hold in the same cycle, mul_ov wins (timeout=0).
  - SETTLE_ST (SETTLE cycles): mul_en=0, mul_rst=0. On the edge ending the last cycle:
    - out_z<=mul_z, out_cycles<=counter, out_timeout<=flag, out_valid<=1.
    - stat_ops+=1 and stat_cyc_acc+=counter, each saturating at all-ones.
    - Go to RESP.
  - RESP: out_valid held with out_z/out_cycles/out_timeout stable. mul_rst=1. On out_valid&&out_ready: out_valid<=0, in_ready<=1, go to IDLE.
- in_ready is 0 in every state except IDLE; there is no pipelining (one operation in flight).
- Latency from acceptance edge to out_valid: 1 (CLEAR) + N (RUN) + SETTLE cycles.
- Cycle counter saturates at all-ones and never wraps. MAX_CYC must be below 2^CYC_W; assertion in simulation.
- mul_ov sampled outside RUN is ignored.
- Reset during any state: immediate return to reset values. The result in flight is discarded and statistics are cleared.
- in_ops changing while not accepted has no effect.

Decomposition:
- Shared package dsc_pkg holds:
  - state enum ctrl_state_t {IDLE, CLEAR, RUN, SETTLE_ST, RESP};
  - localparam PROD_W = NUM_INPUTS*NUM_BITS;
  - function default_max_cyc(PROD_W).
- One natural sub-module: dsc_stat_acc, a saturating ACC_W accumulator used twice (ops and cycles).
- The cycle counter is kept inline rather than reusing counter, because of the saturate and clear-in-CLEAR semantics.

Test Plan:
- All operands 15, real dsc_mul attached: out_z=50625, out_timeout=0, out_cycles≤65536, stat_ops=1, stat_cyc_acc==out_cycles.
- Operands (3,0,7,9): out_z=0. Then operands (1,1,1,1) back-to-back: out_z=1. stat_ops=2, stat_cyc_acc = sum of both out_cycles.
- Stub multiplier asserts mul_ov on the 5th RUN cycle:
  - out_cycles=5;
  - out_valid rises exactly 1+5+SETTLE cycles after acceptance;
  - mul_en is high for exactly 5 cycles;
  - mul_rst pulses in CLEAR.
- Stub never asserts ov, MAX_CYC overridden to 20: out_timeout=1, out_cycles=20. Same stub asserting ov on cycle 20 instead gives out_timeout=0.
- out_ready held low 10 cycles in RESP: out_valid, out_z and out_cycles stay stable, in_ready=0, and a second in_valid is not accepted until the handshake completes.
- rst driven low mid-RUN (cycle 3) for one edge: all outputs return to reset values next cycle, no out_valid is produced, and a fresh operation completes normally.
